// File: rtl/idli_sqi_ctrl.sv
// SQI (quad-SPI) SRAM streaming controller: READ/WRITE command, 24b address, then one slice per cycle.
// Optional write path is built only when IDLI_SQI_WRITE_EN is defined; otherwise every transaction is a READ.
package idli_pkg;
  typedef logic [3:0] slice_t;
  typedef logic [1:0] ctr_t;
endpackage

module idli_sqi_ctrl
  import idli_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_redir,
  input  logic [15:0] i_redir_addr,
  input  logic        i_redir_wr,
  input  logic        i_stall,
  output logic        o_rd_vld,
  output slice_t      o_rd_slice,
  output ctr_t        o_rd_ctr,
  input  slice_t      i_wr_slice,
  output logic        o_wr_rdy,
  output logic        o_sqi_cs_n,
  output logic        o_sqi_sck_en,
  output logic        o_sqi_oe,
  output slice_t      o_sqi_sio,
  input  slice_t      i_sqi_sio
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GAP,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_cnt, w_cnt_nxt;
  logic [15:0] r_addr, w_addr_nxt;
  logic        r_wr, w_wr_nxt, w_redir_wr;
  logic        r_pend, w_go;
  logic        r_cs_n, r_sck, r_oe;
  slice_t      r_sio, w_sio_nxt;
  logic        r_rd_data;
  logic        r_rd_vld;
  slice_t      r_rd_slice;
  ctr_t        r_rd_ctr;
  logic [23:0] w_byte_addr;
  logic [7:0]  w_cmd;
  logic        w_wr_take;

`ifdef IDLI_SQI_WRITE_EN
  logic r_wr_data;

  assign w_redir_wr = i_redir_wr;
  assign w_wr_take  = r_wr_data & ~i_stall;
  assign o_wr_rdy   = w_wr_take;
  assign o_sqi_sio  = w_wr_take ? i_wr_slice : r_sio;
`else
  logic w_unused;

  assign w_redir_wr = 1'b0;
  assign w_wr_take  = 1'b0;
  assign o_wr_rdy   = 1'b0;
  assign o_sqi_sio  = r_sio;
  assign w_unused   = ^{i_wr_slice, i_redir_wr};
`endif

  // A redirect seen during a stall is remembered and acted on once the stall drops.
  assign w_go       = (i_redir | r_pend) & ~i_stall;
  assign w_addr_nxt = i_redir ? i_redir_addr : r_addr;
  assign w_wr_nxt   = i_redir ? w_redir_wr : r_wr;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 3'd1;
    if (w_go) begin
      w_state_nxt = (r_state == ST_IDLE || r_state == ST_GAP) ? ST_CMD : ST_GAP;
      w_cnt_nxt   = 3'd0;
    end else begin
      unique case (r_state)
        ST_GAP: begin
          w_state_nxt = ST_CMD;
          w_cnt_nxt   = 3'd0;
        end
        ST_CMD: if (r_cnt == 3'd1) begin
          w_state_nxt = ST_ADDR;
          w_cnt_nxt   = 3'd0;
        end
        ST_ADDR: if (r_cnt == 3'd5) begin
          w_state_nxt = r_wr ? ST_DATA : ST_DUMMY;
          w_cnt_nxt   = 3'd0;
        end
        ST_DUMMY: if (r_cnt == 3'd1) begin
          w_state_nxt = ST_DATA;
          w_cnt_nxt   = 3'd0;
        end
        default: w_cnt_nxt = r_cnt;
      endcase
    end
  end

  // Pad nibble for the cycle being entered; outputs are registered one step ahead of use.
  always_comb begin
    w_byte_addr = {7'b0, w_addr_nxt, 1'b0};
    w_cmd       = w_wr_nxt ? 8'h02 : 8'h03;
    w_sio_nxt   = w_wr_take ? i_wr_slice : r_sio;
    if (w_state_nxt == ST_CMD) begin
      w_sio_nxt = w_cnt_nxt[0] ? w_cmd[3:0] : w_cmd[7:4];
    end else if (w_state_nxt == ST_ADDR) begin
      unique case (w_cnt_nxt)
        3'd0:    w_sio_nxt = w_byte_addr[23:20];
        3'd1:    w_sio_nxt = w_byte_addr[19:16];
        3'd2:    w_sio_nxt = w_byte_addr[15:12];
        3'd3:    w_sio_nxt = w_byte_addr[11:8];
        3'd4:    w_sio_nxt = w_byte_addr[7:4];
        default: w_sio_nxt = w_byte_addr[3:0];
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 3'd0;
      r_addr     <= 16'd0;
      r_wr       <= 1'b0;
      r_pend     <= 1'b0;
      r_cs_n     <= 1'b1;
      r_sck      <= 1'b0;
      r_oe       <= 1'b0;
      r_sio      <= '0;
      r_rd_data  <= 1'b0;
      r_rd_vld   <= 1'b0;
      r_rd_slice <= '0;
      r_rd_ctr   <= '0;
`ifdef IDLI_SQI_WRITE_EN
      r_wr_data  <= 1'b0;
`endif
    end else begin
      if (i_redir) begin
        r_addr <= i_redir_addr;
        r_wr   <= w_redir_wr;
      end
      r_pend <= i_stall & (i_redir | r_pend);

      // A stall freezes the sequencer and the pad registers; only the gated strobes drop.
      if (!i_stall) begin
        r_state   <= w_state_nxt;
        r_cnt     <= w_cnt_nxt;
        r_cs_n    <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_GAP);
        r_sck     <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_GAP);
        r_oe      <= (w_state_nxt == ST_CMD) || (w_state_nxt == ST_ADDR) ||
                     ((w_state_nxt == ST_DATA) && w_wr_nxt);
        r_sio     <= w_sio_nxt;
        r_rd_data <= (w_state_nxt == ST_DATA) && !w_wr_nxt;
`ifdef IDLI_SQI_WRITE_EN
        r_wr_data <= (w_state_nxt == ST_DATA) && w_wr_nxt;
`endif
      end

      if (w_go) begin
        r_rd_vld <= 1'b0;
        r_rd_ctr <= '0;
      end else if (!i_stall) begin
        if (r_rd_vld) r_rd_ctr <= r_rd_ctr + 2'd1;
        r_rd_vld <= r_rd_data;
        if (r_rd_data) r_rd_slice <= i_sqi_sio;
      end
    end
  end

  assign o_sqi_cs_n   = r_cs_n;
  assign o_sqi_sck_en = r_sck & ~i_stall;
  assign o_sqi_oe     = r_oe;
  assign o_rd_vld     = r_rd_vld & ~i_stall;
  assign o_rd_slice   = r_rd_slice;
  assign o_rd_ctr     = r_rd_ctr;

endmodule

// File: tb/tb_idli_sqi_ctrl.sv
// Directed bench for idli_sqi_ctrl: table-driven read transaction plus hand-written corner sequences.
// Exercises the write path when IDLI_SQI_WRITE_EN is defined, and the read-only fallback otherwise.
module tb_idli_sqi_ctrl;
  import idli_pkg::*;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_redir = 1'b0;
  logic [15:0] i_redir_addr = '0;
  logic        i_redir_wr = 1'b0;
  logic        i_stall = 1'b0;
  slice_t      i_wr_slice = '0;
  slice_t      i_sqi_sio = '0;
  logic        o_rd_vld, o_wr_rdy, o_sqi_cs_n, o_sqi_sck_en, o_sqi_oe;
  slice_t      o_rd_slice, o_sqi_sio;
  ctr_t        o_rd_ctr;

  int n_tests = 0;
  int n_fail  = 0;

  // Packed observation: {cs_n, sck_en, oe, sio[3:0], rd_vld, rd_slice[3:0], rd_ctr[1:0], wr_rdy}
  localparam logic [14:0] M_ALL   = 15'h7FFF;
  localparam logic [14:0] M_NOSIO = 15'h70FF;
  localparam logic [14:0] M_NOSL  = 15'h7F87;
  localparam logic [14:0] M_NONE2 = 15'h7087;

  typedef struct {
    logic        redir;
    logic [15:0] addr;
    logic        wr;
    logic        stall;
    logic [3:0]  sio_in;
    logic [14:0] exp;
    logic [14:0] mask;
  } vec_t;

  vec_t vecs[18];

  idli_sqi_ctrl u_dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_redir      (i_redir),
    .i_redir_addr (i_redir_addr),
    .i_redir_wr   (i_redir_wr),
    .i_stall      (i_stall),
    .o_rd_vld     (o_rd_vld),
    .o_rd_slice   (o_rd_slice),
    .o_rd_ctr     (o_rd_ctr),
    .i_wr_slice   (i_wr_slice),
    .o_wr_rdy     (o_wr_rdy),
    .o_sqi_cs_n   (o_sqi_cs_n),
    .o_sqi_sck_en (o_sqi_sck_en),
    .o_sqi_oe     (o_sqi_oe),
    .o_sqi_sio    (o_sqi_sio),
    .i_sqi_sio    (i_sqi_sio)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [14:0] ex(input logic cs, input logic sck, input logic oe,
                                     input logic [3:0] sio, input logic vld,
                                     input logic [3:0] sl, input logic [1:0] ctr,
                                     input logic wrdy);
    return {cs, sck, oe, sio, vld, sl, ctr, wrdy};
  endfunction

  task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp,
                       input logic [14:0] mask);
    n_tests++;
    if ((act & mask) !== (exp & mask)) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (mask %h)", name, act & mask, exp & mask, mask);
    end
  endtask

  task automatic drv(input logic redir, input logic [15:0] addr, input logic wr,
                     input logic stall, input logic [3:0] sio_in, input logic [3:0] ws);
    @(posedge clk);
    #1;
    i_redir      = redir;
    i_redir_addr = addr;
    i_redir_wr   = wr;
    i_stall      = stall;
    i_sqi_sio    = sio_in;
    i_wr_slice   = ws;
  endtask

  task automatic chk(input string name, input logic [14:0] exp, input logic [14:0] mask);
    @(negedge clk);
    check(name, {o_sqi_cs_n, o_sqi_sck_en, o_sqi_oe, o_sqi_sio, o_rd_vld, o_rd_slice,
                 o_rd_ctr, o_wr_rdy}, exp, mask);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    i_rst = 1'b1;
    i_redir = 1'b0;
    i_stall = 1'b0;
    i_sqi_sio = '0;
    i_wr_slice = '0;
    repeat (2) @(posedge clk);
    #1;
    i_rst = 1'b0;
  endtask

  function automatic vec_t mk(input logic redir, input logic [15:0] addr, input logic [3:0] sio_in,
                              input logic [14:0] exp, input logic [14:0] mask);
    vec_t v;
    v.redir = redir; v.addr = addr; v.wr = 1'b0; v.stall = 1'b0;
    v.sio_in = sio_in; v.exp = exp; v.mask = mask;
    return v;
  endfunction

  initial begin
    // Read of word 0x1234: byte address 0x002468, data A..E from N+11.
    vecs[0]  = mk(1'b1, 16'h1234, 4'h0, ex(1, 0, 0, 4'h0, 0, 4'h0, 2'd0, 0), M_ALL);
    vecs[1]  = mk(1'b0, 16'h0000, 4'h0, ex(0, 1, 1, 4'h0, 0, 4'h0, 2'd0, 0), M_ALL);
    vecs[2]  = mk(1'b0, 16'h0000, 4'h0, ex(0, 1, 1, 4'h3, 0, 4'h0, 2'd0, 0), M_ALL);
    vecs[3]  = mk(1'b0, 16'h0000, 4'h0, ex(0, 1, 1, 4'h0, 0, 4'h0, 2'd0, 0), M_ALL);
    vecs[4]  = mk(1'b0, 16'h0000, 4'h0, ex(0, 1, 1, 4'h0, 0, 4'h0, 2'd0, 0), M_ALL);
    vecs[5]  = mk(1'b0, 16'h0000, 4'h0, ex(0, 1, 1, 4'h2, 0, 4'h0, 2'd0, 0), M_ALL);
    vecs[6]  = mk(1'b0, 16'h0000, 4'h0, ex(0, 1, 1, 4'h4, 0, 4'h0, 2'd0, 0), M_ALL);
    vecs[7]  = mk(1'b0, 16'h0000, 4'h0, ex(0, 1, 1, 4'h6, 0, 4'h0, 2'd0, 0), M_ALL);
    vecs[8]  = mk(1'b0, 16'h0000, 4'h0, ex(0, 1, 1, 4'h8, 0, 4'h0, 2'd0, 0), M_ALL);
    vecs[9]  = mk(1'b0, 16'h0000, 4'h0, ex(0, 1, 0, 4'h0, 0, 4'h0, 2'd0, 0), M_NOSIO);
    vecs[10] = mk(1'b0, 16'h0000, 4'h0, ex(0, 1, 0, 4'h0, 0, 4'h0, 2'd0, 0), M_NOSIO);
    vecs[11] = mk(1'b0, 16'h0000, 4'hA, ex(0, 1, 0, 4'h0, 0, 4'h0, 2'd0, 0), M_NOSIO);
    vecs[12] = mk(1'b0, 16'h0000, 4'hB, ex(0, 1, 0, 4'h0, 1, 4'hA, 2'd0, 0), M_NOSIO);
    vecs[13] = mk(1'b0, 16'h0000, 4'hC, ex(0, 1, 0, 4'h0, 1, 4'hB, 2'd1, 0), M_NOSIO);
    vecs[14] = mk(1'b0, 16'h0000, 4'hD, ex(0, 1, 0, 4'h0, 1, 4'hC, 2'd2, 0), M_NOSIO);
    vecs[15] = mk(1'b0, 16'h0000, 4'hE, ex(0, 1, 0, 4'h0, 1, 4'hD, 2'd3, 0), M_NOSIO);
    vecs[16] = mk(1'b0, 16'h0000, 4'h0, ex(0, 1, 0, 4'h0, 1, 4'hE, 2'd0, 0), M_NOSIO);
    vecs[17] = mk(1'b0, 16'h0000, 4'h0, ex(0, 1, 0, 4'h0, 1, 4'h0, 2'd1, 0), M_NOSIO);

    // Reset then idle for 20 cycles.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drv(1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h0);
      chk($sformatf("idle[%0d]", i), ex(1, 0, 0, 4'h0, 0, 4'h0, 2'd0, 0), M_ALL);
    end

    // Table-driven read transaction.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      drv(vecs[i].redir, vecs[i].addr, vecs[i].wr, vecs[i].stall, vecs[i].sio_in, 4'h0);
      chk($sformatf("read[N+%0d]", i), vecs[i].exp, vecs[i].mask);
    end

    // Redirect during read DATA at N+14.
    do_reset();
    drv(1'b1, 16'h0010, 1'b0, 1'b0, 4'h0, 4'h0);
    for (int i = 1; i <= 10; i++) drv(1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h0);
    drv(1'b0, 16'h0000, 1'b0, 1'b0, 4'h1, 4'h0);
    drv(1'b0, 16'h0000, 1'b0, 1'b0, 4'h2, 4'h0);
    chk("redir N+12", ex(0, 1, 0, 4'h0, 1, 4'h1, 2'd0, 0), M_NOSIO);
    drv(1'b0, 16'h0000, 1'b0, 1'b0, 4'h3, 4'h0);
    chk("redir N+13", ex(0, 1, 0, 4'h0, 1, 4'h2, 2'd1, 0), M_NOSIO);
    drv(1'b1, 16'h00FF, 1'b0, 1'b0, 4'h4, 4'h0);
    chk("redir N+14", ex(0, 1, 0, 4'h0, 1, 4'h3, 2'd2, 0), M_NOSIO);
    drv(1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h0);
    chk("redir gap N+15", ex(1, 0, 0, 4'h0, 0, 4'h0, 2'd0, 0), M_NONE2);
    drv(1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h0);
    chk("redir cmd N+16", ex(0, 1, 1, 4'h0, 0, 4'h0, 2'd0, 0), M_NOSL);
    drv(1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h0);
    chk("redir cmd N+17", ex(0, 1, 1, 4'h3, 0, 4'h0, 2'd0, 0), M_NOSL);
    begin
      logic [3:0] nib [6];
      nib[0] = 4'h0; nib[1] = 4'h0; nib[2] = 4'h0; nib[3] = 4'h1; nib[4] = 4'hF; nib[5] = 4'hE;
      for (int i = 0; i < 6; i++) begin
        drv(1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h0);
        chk($sformatf("redir addr[%0d]", i), ex(0, 1, 1, nib[i], 0, 4'h0, 2'd0, 0), M_NOSL);
      end
    end

    // Stall for 3 cycles at N+5 (mid-ADDR), then stalls in DATA and a stalled redirect.
    do_reset();
    drv(1'b1, 16'h1234, 1'b0, 1'b0, 4'h0, 4'h0);
    for (int i = 1; i <= 4; i++) drv(1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h0);
    chk("stall N+4", ex(0, 1, 1, 4'h0, 0, 4'h0, 2'd0, 0), M_ALL);
    for (int i = 5; i <= 7; i++) begin
      drv(1'b0, 16'h0000, 1'b0, 1'b1, 4'h0, 4'h0);
      chk($sformatf("stall hold N+%0d", i), ex(0, 0, 1, 4'h2, 0, 4'h0, 2'd0, 0), M_ALL);
    end
    drv(1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h0);
    chk("stall resume N+8", ex(0, 1, 1, 4'h2, 0, 4'h0, 2'd0, 0), M_ALL);
    drv(1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h0);
    chk("stall N+9", ex(0, 1, 1, 4'h4, 0, 4'h0, 2'd0, 0), M_ALL);
    for (int i = 10; i <= 13; i++) drv(1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h0);
    drv(1'b0, 16'h0000, 1'b0, 1'b0, 4'h7, 4'h0);
    chk("stall N+14", ex(0, 1, 0, 4'h0, 0, 4'h0, 2'd0, 0), M_NOSIO);
    drv(1'b0, 16'h0000, 1'b0, 1'b0, 4'h9, 4'h0);
    chk("stall first data N+15", ex(0, 1, 0, 4'h0, 1, 4'h7, 2'd0, 0), M_NOSIO);
    drv(1'b0, 16'h0000, 1'b0, 1'b1, 4'h5, 4'h0);
    chk("stall data N+16", ex(0, 0, 0, 4'h0, 0, 4'h9, 2'd1, 0), M_NOSIO);
    drv(1'b0, 16'h0000, 1'b0, 1'b0, 4'h3, 4'h0);
    chk("stall data N+17", ex(0, 1, 0, 4'h0, 1, 4'h9, 2'd1, 0), M_NOSIO);
    drv(1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h0);
    chk("stall data N+18", ex(0, 1, 0, 4'h0, 1, 4'h3, 2'd2, 0), M_NOSIO);
    drv(1'b1, 16'h0003, 1'b0, 1'b1, 4'h0, 4'h0);
    chk("stalled redir N+19", ex(0, 0, 0, 4'h0, 0, 4'h0, 2'd0, 0), 15'h7080);
    drv(1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h0);
    chk("stalled redir N+20", ex(0, 1, 0, 4'h0, 0, 4'h0, 2'd0, 0), 15'h7000);
    drv(1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h0);
    chk("stalled redir gap", ex(1, 0, 0, 4'h0, 0, 4'h0, 2'd0, 0), M_NONE2);
    drv(1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h0);
    chk("stalled redir cmd0", ex(0, 1, 1, 4'h0, 0, 4'h0, 2'd0, 0), M_NOSL);
    drv(1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h0);
    chk("stalled redir cmd1", ex(0, 1, 1, 4'h3, 0, 4'h0, 2'd0, 0), M_NOSL);
    for (int i = 0; i < 5; i++) drv(1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h0);
    drv(1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h0);
    chk("stalled redir addr5", ex(0, 1, 1, 4'h6, 0, 4'h0, 2'd0, 0), M_NOSL);

    // Reset at N+4 mid-ADDR, then a fresh redirect at N+6.
    do_reset();
    drv(1'b1, 16'h1234, 1'b0, 1'b0, 4'h0, 4'h0);
    for (int i = 1; i <= 3; i++) drv(1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h0);
    drv(1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h0);
    i_rst = 1'b1;
    chk("rst N+4 still addr", ex(0, 1, 1, 4'h0, 0, 4'h0, 2'd0, 0), M_ALL);
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    chk("rst N+5 idle", ex(1, 0, 0, 4'h0, 0, 4'h0, 2'd0, 0), M_ALL);
    drv(1'b1, 16'h0002, 1'b0, 1'b0, 4'h0, 4'h0);
    chk("rst N+6 idle", ex(1, 0, 0, 4'h0, 0, 4'h0, 2'd0, 0), M_ALL);
    drv(1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h0);
    chk("rst N+7 cmd0", ex(0, 1, 1, 4'h0, 0, 4'h0, 2'd0, 0), M_ALL);
    drv(1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h0);
    chk("rst N+8 cmd1", ex(0, 1, 1, 4'h3, 0, 4'h0, 2'd0, 0), M_ALL);

    // Write redirect to word 0x0001 (byte address 0x000002).
    do_reset();
    drv(1'b1, 16'h0001, 1'b1, 1'b0, 4'h0, 4'h0);
    chk("wr N", ex(1, 0, 0, 4'h0, 0, 4'h0, 2'd0, 0), M_ALL);
    drv(1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h0);
    chk("wr cmd0", ex(0, 1, 1, 4'h0, 0, 4'h0, 2'd0, 0), M_ALL);
    drv(1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h0);
`ifdef IDLI_SQI_WRITE_EN
    chk("wr cmd1", ex(0, 1, 1, 4'h2, 0, 4'h0, 2'd0, 0), M_ALL);
    for (int i = 3; i <= 7; i++) drv(1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h0);
    drv(1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h0);
    chk("wr addr5", ex(0, 1, 1, 4'h2, 0, 4'h0, 2'd0, 0), M_ALL);
    drv(1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h5);
    chk("wr data N+9", ex(0, 1, 1, 4'h5, 0, 4'h0, 2'd0, 1), M_ALL);
    drv(1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h6);
    chk("wr data N+10", ex(0, 1, 1, 4'h6, 0, 4'h0, 2'd0, 1), M_ALL);
    drv(1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h7);
    chk("wr data N+11", ex(0, 1, 1, 4'h7, 0, 4'h0, 2'd0, 1), M_ALL);
    drv(1'b0, 16'h0000, 1'b0, 1'b1, 4'h0, 4'hA);
    chk("wr stall N+12", ex(0, 0, 1, 4'h7, 0, 4'h0, 2'd0, 0), M_ALL);
    drv(1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 4'hB);
    chk("wr data N+13", ex(0, 1, 1, 4'hB, 0, 4'h0, 2'd0, 1), M_ALL);
`else
    chk("wr-as-read cmd1", ex(0, 1, 1, 4'h3, 0, 4'h0, 2'd0, 0), M_ALL);
    for (int i = 3; i <= 8; i++) drv(1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h0);
    drv(1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h5);
    chk("wr-as-read dummy N+9", ex(0, 1, 0, 4'h0, 0, 4'h0, 2'd0, 0), M_NOSIO);
    drv(1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h5);
    drv(1'b0, 16'h0000, 1'b0, 1'b0, 4'h6, 4'h5);
    chk("wr-as-read N+11", ex(0, 1, 0, 4'h0, 0, 4'h0, 2'd0, 0), M_NOSIO);
    drv(1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h5);
    chk("wr-as-read N+12", ex(0, 1, 0, 4'h0, 1, 4'h6, 2'd0, 0), M_NOSIO);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
